// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle control sequencer: internal states,
// phase codes seen by the datapath, RV32I opcodes and ALU operation codes.
`timescale 1ns/1ps
package controle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_LWB    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] EST_FETCH  = 3'b000;
  localparam logic [2:0] EST_DECODE = 3'b001;
  localparam logic [2:0] EST_EXEC   = 3'b010;
  localparam logic [2:0] EST_MEM    = 3'b011;
  localparam logic [2:0] EST_HALT   = 3'b111;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IALU, OP_LW, OP_SW, OP_BEQ: opcode_legal = 1'b1;
      default:                             opcode_legal = 1'b0;
    endcase
  endfunction

  // LWB shares the EXEC/WB phase code because the register bank only writes in 010
  function automatic logic [2:0] estado_of(input state_t s);
    case (s)
      ST_FETCH:  estado_of = EST_FETCH;
      ST_DECODE: estado_of = EST_DECODE;
      ST_EXEC:   estado_of = EST_EXEC;
      ST_MEM:    estado_of = EST_MEM;
      ST_LWB:    estado_of = EST_EXEC;
      ST_HALT:   estado_of = EST_HALT;
      default:   estado_of = EST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/gerador_imediato.sv
// Combinational immediate generator: sign-extends the I, S or B immediate
// selected by the opcode; R-type and unknown opcodes yield zero.
`timescale 1ns/1ps
module gerador_imediato
  import controle_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  // Select immediate layout by instruction format
  always_comb begin
    imm = 32'd0;
    case (ir[6:0])
      OP_IALU, OP_LW: imm = {{20{ir[31]}}, ir[31:20]};
      OP_SW:          imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BEQ:         imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:        imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control sequencer: owns PC and IR, decodes the RV32I subset and
// drives the phase code and registered strobes for regfile, ALU and memory.
`timescale 1ns/1ps
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter logic [31:0] PC_RESET     = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrucao,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [2:0]  estado,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [3:0]  funct,
  output logic [1:0]  aluop,
  output logic        alusrc,
  output logic        regiwrite,
  output logic        memtoreg,
  output logic        memread,
  output logic        memwrite,
  output logic        halted
);

  state_t      state_r, state_nx_s;
  logic [31:0] ir_r, pc_r, pc_nx_s;
  logic [2:0]  estado_r, estado_nx_s;
  logic        regiwrite_r, memtoreg_r, memread_r, memwrite_r, halted_r;
  logic        regiwrite_nx_s, memtoreg_nx_s, memread_nx_s, memwrite_nx_s, halted_nx_s;
  logic [6:0]  opcode_s;
  logic        is_lw_s, is_sw_s, is_beq_s, is_alu_s, rd_nz_s;

  assign opcode_s = ir_r[6:0];
  assign is_lw_s  = (opcode_s == OP_LW);
  assign is_sw_s  = (opcode_s == OP_SW);
  assign is_beq_s = (opcode_s == OP_BEQ);
  assign is_alu_s = (opcode_s == OP_R) || (opcode_s == OP_IALU);
  assign rd_nz_s  = (ir_r[11:7] != 5'd0);

  assign rs1   = ir_r[19:15];
  assign rs2   = ir_r[24:20];
  assign rd    = ir_r[11:7];
  assign funct = {ir_r[30], ir_r[14:12]};

  gerador_imediato u_imm (
    .ir  (ir_r),
    .imm (imm)
  );

  // State, PC, IR and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      pc_r        <= PC_RESET;
      ir_r        <= 32'd0;
      estado_r    <= EST_FETCH;
      regiwrite_r <= 1'b0;
      memtoreg_r  <= 1'b0;
      memread_r   <= 1'b0;
      memwrite_r  <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      ir_r        <= (state_r == ST_FETCH) ? instrucao : ir_r;
      estado_r    <= estado_nx_s;
      regiwrite_r <= regiwrite_nx_s;
      memtoreg_r  <= memtoreg_nx_s;
      memread_r   <= memread_nx_s;
      memwrite_r  <= memwrite_nx_s;
      halted_r    <= halted_nx_s;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    case (state_r)
      ST_FETCH: state_nx_s = ST_DECODE;
      ST_DECODE: begin
        if (!opcode_legal(opcode_s) || (HALT_ON_ZERO && (ir_r == 32'd0))) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_lw_s || is_sw_s) begin
          state_nx_s = ST_MEM;
        end else if (is_beq_s && zero) begin
          state_nx_s = ST_FETCH;
          pc_nx_s    = pc_r + imm;
        end else begin
          state_nx_s = ST_FETCH;
          pc_nx_s    = pc_r + PC_STEP;
        end
      end
      ST_MEM: begin
        if (is_lw_s) begin
          state_nx_s = ST_LWB;
        end else begin
          state_nx_s = ST_FETCH;
          pc_nx_s    = pc_r + PC_STEP;
        end
      end
      ST_LWB: begin
        state_nx_s = ST_FETCH;
        pc_nx_s    = pc_r + PC_STEP;
      end
      ST_HALT: state_nx_s = ST_HALT;
      default: state_nx_s = ST_FETCH;
    endcase
  end

  // Strobes for the upcoming state, so the registers line up with it exactly
  always_comb begin
    estado_nx_s    = estado_of(state_nx_s);
    regiwrite_nx_s = 1'b0;
    memtoreg_nx_s  = 1'b0;
    memread_nx_s   = 1'b0;
    memwrite_nx_s  = 1'b0;
    halted_nx_s    = 1'b0;
    case (state_nx_s)
      ST_EXEC: regiwrite_nx_s = is_alu_s && rd_nz_s;
      ST_MEM: begin
        memread_nx_s  = is_lw_s;
        memwrite_nx_s = is_sw_s;
      end
      ST_LWB: begin
        regiwrite_nx_s = rd_nz_s;
        memtoreg_nx_s  = 1'b1;
        memread_nx_s   = 1'b1;
      end
      ST_HALT: halted_nx_s = 1'b1;
      default: halted_nx_s = 1'b0;
    endcase
  end

  // ALU operation select derived from the held instruction
  always_comb begin
    aluop  = ALU_ADD;
    alusrc = 1'b0;
    case (opcode_s)
      OP_R:          aluop = ALU_FUNCT;
      OP_IALU: begin
        aluop  = ALU_FUNCT;
        alusrc = 1'b1;
      end
      OP_LW, OP_SW: begin
        aluop  = ALU_ADD;
        alusrc = 1'b1;
      end
      OP_BEQ:        aluop = ALU_SUB;
      default:       aluop = ALU_ADD;
    endcase
  end

  assign pc        = pc_r;
  assign estado    = estado_r;
  assign regiwrite = regiwrite_r;
  assign memtoreg  = memtoreg_r;
  assign memread   = memread_r;
  assign memwrite  = memwrite_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: hand-computed phase codes, strobes,
// immediates and PC values for add, lw, sw, addi x0, beq, halt and reset cases.
`timescale 1ns/1ps
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrucao;
  logic        zero;
  logic [31:0] pc, imm;
  logic [2:0]  estado;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  funct;
  logic [1:0]  aluop;
  logic        alusrc, regiwrite, memtoreg, memread, memwrite, halted;

  int n_checks = 0;
  int n_pass   = 0;

  controle_multiciclo dut (
    .clk       (clk),
    .reset     (reset),
    .instrucao (instrucao),
    .zero      (zero),
    .pc        (pc),
    .estado    (estado),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .funct     (funct),
    .aluop     (aluop),
    .alusrc    (alusrc),
    .regiwrite (regiwrite),
    .memtoreg  (memtoreg),
    .memread   (memread),
    .memwrite  (memwrite),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check phase code plus the four strobes as one packed vector {regiwrite,memtoreg,memread,memwrite}
  task automatic check_phase(input string tag, input logic [2:0] est, input logic [3:0] strb);
    check({tag, "_estado"}, 32'(estado), 32'(est));
    check({tag, "_strobes"}, 32'({regiwrite, memtoreg, memread, memwrite}), 32'(strb));
  endtask

  // Run a three-cycle instruction (FETCH, DECODE, EXEC) without checks
  task automatic run3(input logic [31:0] instr, input logic z);
    instrucao = instr;
    zero      = z;
    step();
    step();
    step();
  endtask

  initial begin
    reset     = 1'b1;
    instrucao = 32'd0;
    zero      = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_phase("reset", 3'b000, 4'b0000);
    check("reset_pc", pc, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);

    // add x3,x1,x2 at pc=0
    instrucao = 32'h002081B3;
    step();
    check_phase("add_dec", 3'b001, 4'b0000);
    check("add_rd", 32'(rd), 32'd3);
    check("add_rs1", 32'(rs1), 32'd1);
    check("add_rs2", 32'(rs2), 32'd2);
    check("add_imm", imm, 32'd0);
    step();
    check_phase("add_exec", 3'b010, 4'b1000);
    check("add_aluop", 32'(aluop), 32'd2);
    check("add_alusrc", 32'(alusrc), 32'd0);
    step();
    check_phase("add_fetch", 3'b000, 4'b0000);
    check("add_pc", pc, 32'd4);

    // lw x5,8(x1) at pc=4
    instrucao = 32'h0080A283;
    step();
    check_phase("lw_dec", 3'b001, 4'b0000);
    check("lw_imm", imm, 32'd8);
    check("lw_rd", 32'(rd), 32'd5);
    step();
    check_phase("lw_exec", 3'b010, 4'b0000);
    check("lw_aluop", 32'(aluop), 32'd0);
    check("lw_alusrc", 32'(alusrc), 32'd1);
    step();
    check_phase("lw_mem", 3'b011, 4'b0010);
    step();
    check_phase("lw_wb", 3'b010, 4'b1110);
    check("lw_pc_hold", pc, 32'd4);
    step();
    check_phase("lw_fetch", 3'b000, 4'b0000);
    check("lw_pc", pc, 32'd8);

    // sw x2,12(x1) at pc=8
    instrucao = 32'h0020A623;
    step();
    check("sw_imm", imm, 32'd12);
    step();
    check_phase("sw_exec", 3'b010, 4'b0000);
    step();
    check_phase("sw_mem", 3'b011, 4'b0001);
    step();
    check_phase("sw_fetch", 3'b000, 4'b0000);
    check("sw_pc", pc, 32'd12);

    // addi x0,x0,5 at pc=12: no write-back to x0
    instrucao = 32'h00500013;
    step();
    step();
    check_phase("addi0_exec", 3'b010, 4'b0000);
    check("addi0_alusrc", 32'(alusrc), 32'd1);
    step();
    check("addi0_pc", pc, 32'd16);

    // beq x1,x2,-8 at pc=16, taken
    instrucao = 32'hFE208CE3;
    zero      = 1'b1;
    step();
    check("beq_imm", imm, 32'hFFFF_FFF8);
    step();
    check_phase("beq_exec", 3'b010, 4'b0000);
    check("beq_aluop", 32'(aluop), 32'd1);
    step();
    check("beq_taken_pc", pc, 32'd8);

    // walk back to pc=16, then beq not taken
    run3(32'h00500013, 1'b0);
    check("walk_pc12", pc, 32'd12);
    run3(32'h00500013, 1'b0);
    check("walk_pc16", pc, 32'd16);
    run3(32'hFE208CE3, 1'b0);
    check("beq_not_taken_pc", pc, 32'd20);

    // all-zero instruction halts at pc=20
    instrucao = 32'd0;
    step();
    check_phase("halt_dec", 3'b001, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      instrucao = 32'h002081B3;
      step();
      check_phase("halt_hold", 3'b111, 4'b0000);
      check("halt_pc", pc, 32'd20);
      check("halt_flag", 32'(halted), 32'd1);
    end

    reset = 1'b1;
    step();
    reset = 1'b0;
    check_phase("halt_reset", 3'b000, 4'b0000);
    check("halt_reset_pc", pc, 32'd0);
    check("halt_reset_flag", 32'(halted), 32'd0);

    // reset in the middle of lw, during MEM
    instrucao = 32'h0080A283;
    step();
    step();
    step();
    check_phase("abort_mem", 3'b011, 4'b0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_phase("abort_reset", 3'b000, 4'b0000);
    check("abort_pc", pc, 32'd0);
    step();
    check_phase("abort_refetch", 3'b001, 4'b0000);

    // illegal opcode halts as well
    reset = 1'b1;
    step();
    reset     = 1'b0;
    instrucao = 32'h0000007F;
    step();
    step();
    check_phase("illegal_halt", 3'b111, 4'b0000);
    check("illegal_halted", 32'(halted), 32'd1);
    check("illegal_pc", pc, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control sequencer: the initiator that drives the register bank's state-gated access interface (estado, rs1/rs2/rd, regiwrite, memtoreg).
- Owns the PC and the instruction register (IR); decodes RV32I subset (R-type, addi/I-ALU, lw, sw, beq).
- Emits per-phase control to regfile, ALU, data memory.
- Register bank commits reads and writes only while estado==3'b010, so every write-back is presented in an estado 010 phase.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset
- PC_STEP, 4, sequential PC increment
- HALT_ON_ZERO, 1, IR==0 enters HALT

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- instrucao  in  32  instruction memory data at address pc, valid in FETCH
- zero  in  1  ALU zero flag, sampled at end of EXEC
- pc  out  32  current instruction address
- estado  out  3  phase code to datapath: 000 FETCH, 001 DECODE, 010 EXEC/WB, 011 MEM, 111 HALT
- rs1, rs2, rd  out  5 each  IR[19:15], IR[24:20], IR[11:7]
- imm  out  32  sign-extended immediate (I/S/B formats; 0 for R-type)
- funct  out  4  {IR[30], IR[14:12]}
- aluop  out  2  00 add, 01 sub, 10 decode funct
- alusrc  out  1  1 = ALU B operand is imm
- regiwrite, memtoreg  out  1 each  regfile write enable / select memory data
- memread, memwrite  out  1 each  data memory strobes
- halted  out  1  sticky halt indicator

Behaviour:
- Reset (sync, any state, incl. mid-instruction): next edge estado=000, pc=PC_RESET, IR=0, halted=0, all strobes 0. An aborted instruction produces no regiwrite/memwrite.
- Internal states: FETCH, DECODE, EXEC, MEM, LWB. LWB drives estado=010, the same code as EXEC.
- FETCH: IR<=instrucao; next DECODE.
- DECODE: opcode checked:
  - Illegal opcode, or IR==0 with HALT_ON_ZERO=1 -> HALT.
  - Otherwise -> EXEC.
- EXEC (010): aluop/alusrc valid.
  - R-type / I-ALU: regiwrite=1, memtoreg=0; next FETCH; pc+=PC_STEP.
  - beq: aluop=01; regiwrite=0. If zero, pc<=pc+imm, else pc+=PC_STEP; next FETCH.
  - lw/sw: aluop=00, alusrc=1, regiwrite=0; next MEM.
- MEM (011):
  - lw: memread=1; next LWB.
  - sw: memwrite=1; pc+=PC_STEP; next FETCH.
- LWB (estado 010): regiwrite=1, memtoreg=1, memread held 1; pc+=PC_STEP; next FETCH.
- HALT (111): halted=1, pc and IR frozen, all strobes 0; exits only via reset.
- Latency in cycles: R/I/beq 3, sw 4, lw 5.
- Timing of outputs:
  - Strobes (regiwrite, memread, memwrite, memtoreg) are registered alongside the state, valid for exactly the state's cycle, 0 elsewhere.
  - rs1/rs2/rd/imm/funct derive combinationally from IR; stable from DECODE through the end of the instruction.
- rd==0: regiwrite forced 0.
- PC arithmetic: 32-bit, wraps modulo 2^32, no fault.
- B-imm: {IR[31], IR[7], IR[30:25], IR[11:8], 0} sign-extended.

Decomposition:
- Package controle_pkg: state encodings, estado codes, opcode constants (0110011, 0010011, 0000011, 0100011, 1100011), aluop codes.
- One sub-module: gerador_imediato (combinational IR -> imm by format).

Test Plan:
- add x3,x1,x2 (0x002081B3) at pc=0 -> estado 000,001,010,000; regiwrite=1 only in 010; rd=3; pc=4.
- lw x5,8(x1) (0x0080A283) -> estado 000,001,010,011,010.
  - memread=1 in 011; imm=8.
  - regiwrite=memtoreg=1 only in the second 010.
  - pc+=4.
- sw x2,12(x1) (0x0020A623) -> memwrite=1 only in 011; imm=12; regiwrite never 1.
- beq x1,x2,-8 (0xFE208CE3) at pc=16 -> zero=1: pc=8; zero=0: pc=20; imm=0xFFFFFFF8.
- addi x0,x0,5 (0x00500013) -> regiwrite stays 0; pc advances by 4.
- instrucao=0x00000000 -> estado 111, halted=1, pc frozen 10 cycles.
  - reset -> estado 000, pc=0.
  - reset asserted during lw MEM -> next estado 000, no regiwrite pulse.
